// File: rtl/multi_edge_detector.sv
// Multi-channel synchronise/debounce/edge detector with masked event strobes and a saturating event counter.
// Define EDGE_DET_STICKY_IRQ_EN to add sticky per-channel status flags and a registered interrupt.
module multi_edge_detector #(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16,
   parameter bit RESET_LEVEL     = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH-1:0]     din_i,
   input  logic [2*NUM_CH-1:0]   mode_i,
   input  logic                  cnt_clr_i,
   output logic [NUM_CH-1:0]     level_o,
   output logic [NUM_CH-1:0]     rise_o,
   output logic [NUM_CH-1:0]     fall_o,
   output logic [NUM_CH-1:0]     event_o,
   output logic [CNT_W-1:0]      event_count_o,
   output logic [NUM_CH-1:0]     status_o,
   input  logic [NUM_CH-1:0]     status_clr_i,
   input  logic [NUM_CH-1:0]     irq_mask_i,
   output logic                  irq_o
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PC_W  = $clog2(NUM_CH + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
   logic [NUM_CH-1:0] sync_last;
   logic [DB_W-1:0]   db_cnt [NUM_CH];
   logic [NUM_CH-1:0] level_q;
   logic [NUM_CH-1:0] prev_q;
   logic [NUM_CH-1:0] rise_q;
   logic [NUM_CH-1:0] fall_q;
   logic [NUM_CH-1:0] event_q;
   logic [NUM_CH-1:0] rise_en;
   logic [NUM_CH-1:0] fall_en;
   logic [PC_W-1:0]   ev_pop;
   logic [SUM_W-1:0]  cnt_sum;
   logic [CNT_W-1:0]  count_next;
   logic [CNT_W-1:0]  count_q;

   assign sync_last = sync_q[SYNC_STAGES-1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= {NUM_CH{RESET_LEVEL}};
      end else begin
         sync_q[0] <= din_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= {NUM_CH{RESET_LEVEL}};
         for (int i = 0; i < NUM_CH; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync_last[i] == level_q[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_cnt[i]  <= '0;
               level_q[i] <= ~level_q[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rise_en = '0;
      fall_en = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rise_en[i] = mode_i[2*i];
         fall_en[i] = mode_i[2*i+1];
      end
   end

   // prev_q shares the level reset value, so reset release never looks like a transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= {NUM_CH{RESET_LEVEL}};
         rise_q  <= '0;
         fall_q  <= '0;
         event_q <= '0;
      end else begin
         prev_q  <= level_q;
         rise_q  <= level_q & ~prev_q;
         fall_q  <= ~level_q & prev_q;
         event_q <= (level_q & ~prev_q & rise_en) | (~level_q & prev_q & fall_en);
      end
   end

   always_comb begin
      ev_pop = '0;
      for (int i = 0; i < NUM_CH; i++) ev_pop = ev_pop + PC_W'(event_q[i]);
   end

   // A clear still loads this cycle's events so none are lost.
   always_comb begin
      cnt_sum    = (cnt_clr_i ? '0 : SUM_W'(count_q)) + SUM_W'(ev_pop);
      count_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_next;
   end

   assign level_o       = level_q;
   assign rise_o        = rise_q;
   assign fall_o        = fall_q;
   assign event_o       = event_q;
   assign event_count_o = count_q;

`ifdef EDGE_DET_STICKY_IRQ_EN
   logic [NUM_CH-1:0] status_q;
   logic              irq_q;

   // Set beats clear when both land on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= (status_q & ~status_clr_i) | event_q;
         irq_q    <= |(status_q & irq_mask_i);
      end
   end

   assign status_o = status_q;
   assign irq_o    = irq_q;
`else
   logic unused_sticky_inputs;

   assign unused_sticky_inputs = ^{status_clr_i, irq_mask_i};
   assign status_o             = '0;
   assign irq_o                = 1'b0;
`endif

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit edge detector.
- Per channel: input synchroniser, stability (debounce) filter, registered rise/fall pulses, and a per-channel mode select that masks those pulses into event strobes.
- A saturating global event counter totals all event strobes.
- Sits between asynchronous/noisy inputs (buttons, external status lines) and control logic or an interrupt aggregator.

Parameters:
- NUM_CH, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must differ from the filtered level before the filtered level changes (>=1).
- CNT_W, 16, width of the global event counter.
- RESET_LEVEL, 0, reset value of the synchroniser chain and filtered level.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din_i  input  NUM_CH  raw asynchronous inputs, one bit per channel.
- mode_i  input  2*NUM_CH  per-channel mode; bits [2i+1:2i] = {fall_en, rise_en}.
- cnt_clr_i  input  1  synchronous clear of event_count_o.
- level_o  output  NUM_CH  filtered (debounced) level per channel.
- rise_o  output  NUM_CH  one-cycle pulse on filtered 0->1, unmasked.
- fall_o  output  NUM_CH  one-cycle pulse on filtered 1->0, unmasked.
- event_o  output  NUM_CH  (rise_o & rise_en) | (fall_o & fall_en), per channel.
- event_count_o  output  CNT_W  saturating total of event_o bits.
- status_o  output  NUM_CH  sticky event flags (optional feature).
- status_clr_i  input  NUM_CH  write-1-to-clear for status_o (optional feature).
- irq_mask_i  input  NUM_CH  interrupt enable per channel (optional feature).
- irq_o  output  1  registered interrupt (optional feature).

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - synchroniser chain, level_o and the mirror register all = RESET_LEVEL;
  - debounce counters = 0;
  - rise_o, fall_o, event_o, event_count_o, status_o and irq_o all = 0.
- No edge pulse is generated on reset release.
- Reset asserted mid-debounce discards the partial count.
- Synchroniser: din_i passes through SYNC_STAGES flops per channel. sync[i] is the last stage.
- Debounce, per channel:
  - If sync != level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, level toggles and the counter returns to 0 on that same edge.
  - Any cycle with sync == level resets the counter to 0. A glitch shorter than DEBOUNCE_CYCLES is therefore fully rejected.
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
- Edge detection:
  - A register holds the previous level.
  - rise_o = level & ~prev and fall_o = ~level & prev, both registered: exactly one cycle high per filtered transition.
  - Rise and fall are never simultaneous on one channel.
- Latency: a clean step on din_i sampled at edge 0 updates level_o at edge SYNC_STAGES+DEBOUNCE_CYCLES-1. rise_o/fall_o are high for the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults give edge 5 for level_o and edge 6 for the pulse.
- event_o is registered in the same cycle as rise_o/fall_o, masked by mode_i sampled on that edge. mode 00 = off, 01 = rise, 10 = fall, 11 = both.
- event_count_o:
  - Each cycle adds popcount(event_o); multiple channels in one cycle all count.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr_i=1 loads popcount(event_o) of that cycle, so clear plus simultaneous events loses no events.
- All channels are fully independent; no cross-channel state.

Optional Feature:
- Macro: EDGE_DET_STICKY_IRQ_EN.
- Defined:
  - status_o[i] sets on event_o[i] and clears on status_clr_i[i]; set wins when both occur in the same cycle.
  - irq_o is registered OR of (status_o & irq_mask_i), one cycle after the status change.
- Undefined:
  - status_o and irq_o are tied to 0.
  - status_clr_i and irq_mask_i are ignored.
  - No status registers are synthesised.

Test Plan:
- Reset release with din_i=0, then hold for 20 cycles -> rise_o/fall_o/event_o stay 0, event_count_o=0, level_o=0.
- ch0 step 0->1 at edge 0 (defaults), mode_i=01 -> level_o[0]=1 after edge 5; rise_o[0]=1 and event_o[0]=1 only in the cycle after edge 6; event_count_o=1.
- ch1 glitch high for 3 cycles (< DEBOUNCE_CYCLES=4) -> no level_o change, no pulses. Glitch of 4 cycles -> rise then, after return, fall; mode_i=10 counts only the fall.
- All 4 channels step 0->1 together, mode 11 each -> event_o=4'b1111 in one cycle, event_count_o +4. Same cycle with cnt_clr_i=1 -> event_count_o=4.
- CNT_W=3, 9 events -> event_count_o saturates at 7, stays 7; cnt_clr_i -> 0.
- With EDGE_DET_STICKY_IRQ_EN, irq_mask_i=0001:
  - ch0 event -> status_o[0]=1; irq_o=1 next cycle.
  - status_clr_i[0] together with a new ch0 event -> status_o[0] stays 1.
  - Clear alone -> status_o[0]=0; irq_o=0 one cycle later.
  - Without the macro -> status_o and irq_o stay 0.
